// File: rtl/load_align_unit_pkg.sv
// Shared load-type codes, extension modes, FSM states and small helpers
// for the load alignment path.
package load_align_unit_pkg;

    // Load type encodings carried on req_type
    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    // Extension mode shared with the 8/16-bit extenders
    localparam logic EXT_SIGNED = 1'b1;
    localparam logic EXT_ZERO   = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } load_state_t;

    // Byte extender: signed mode replicates bit 7, otherwise zero-fills
    function automatic logic [31:0] ext8(input logic [7:0] v, input logic mode);
        return {{24{(mode == EXT_SIGNED) & v[7]}}, v};
    endfunction

    // Halfword extender: signed mode replicates bit 15, otherwise zero-fills
    function automatic logic [31:0] ext16(input logic [15:0] v, input logic mode);
        return {{16{(mode == EXT_SIGNED) & v[15]}}, v};
    endfunction

    // Unknown load types fall into the word case, so they need full alignment
    function automatic logic is_misaligned(input logic [2:0] ld_type, input logic [1:0] off);
        logic bad;
        case (ld_type)
            LD_LB, LD_LBU: bad = 1'b0;
            LD_LH, LD_LHU: bad = off[0];
            default:       bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align_unit_lane_ext.sv
// Combinational lane selector and extender: picks the addressed byte or
// halfword out of a little-endian word and widens it to 32 bits.
module load_lane_ext
    import load_align_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_type,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the byte lane from addr[1:0] and the halfword lane from addr[1]
    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane; anything not a byte/half load returns the whole word
    always_comb begin
        ext = rdata;
        case (ld_type)
            LD_LB:   ext = ext8(byte_sel, EXT_SIGNED);
            LD_LBU:  ext = ext8(byte_sel, EXT_ZERO);
            LD_LH:   ext = ext16(half_sel, EXT_SIGNED);
            LD_LHU:  ext = ext16(half_sel, EXT_ZERO);
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load path controller: accepts one load at a time, issues a word-aligned
// read, waits (optionally bounded) for the data and returns the extended
// result with its destination register.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [4:0]        req_rd,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err
);

    // Counter only needs to reach MEM_TIMEOUT-1; with no timeout it just wraps
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    load_state_t        state;
    logic [1:0]         lat_off;
    logic [2:0]         lat_type;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [31:0]        ext_data;
    logic               tmo_hit;

    load_lane_ext u_lane_ext (
        .rdata   (mem_rdata),
        .off     (lat_off),
        .ld_type (lat_type),
        .ext     (ext_data)
    );

    // Timeout fires on the last permitted READ cycle when a bound is configured
    always_comb begin
        tmo_hit = (MEM_TIMEOUT != 0) && (32'(tmo_cnt) == MEM_TIMEOUT - 1);
    end

    // Main FSM with registered handshake, memory strobe and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
            lat_off    <= '0;
            lat_type   <= LD_LW;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_off   <= req_addr[1:0];
                        lat_type  <= req_type;
                        resp_rd   <= req_rd;
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        req_ready <= 1'b0;
                        tmo_cnt   <= '0;
                        if (is_misaligned(req_type, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            state      <= ST_RESP;
                        end else begin
                            mem_rd_en <= 1'b1;
                            state     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_rvalid) begin
                        resp_data  <= ext_data;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        mem_rd_en  <= 1'b0;
                        state      <= ST_RESP;
                    end else if (tmo_hit) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        mem_rd_en  <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed corner cases followed by
// randomized loads, all compared against an arithmetic reference model.
module tb_load_align_unit;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_type;
    logic [4:0]        req_rd;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic              resp_err;

    int errorCount = 0;
    int checkCount = 0;

    load_align_unit #(
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .req_rd     (req_rd),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no_finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Access size in bytes; codes 0 and 5..7 behave as word loads
    function automatic int accessSize(input int t);
        if (t == 3 || t == 4) return 1;
        if (t == 1 || t == 2) return 2;
        return 4;
    endfunction

    function automatic bit refErr(input int t, input longint addr);
        return (addr % accessSize(t)) != 0;
    endfunction

    // Reference result from plain arithmetic on the word
    function automatic logic [31:0] refData(input int t, input longint addr, input longint word);
        int     size;
        longint shiftAmt;
        longint val;
        longint span;
        size = accessSize(t);
        if (refErr(t, addr)) return 32'h0;
        if (size == 4) return word[31:0];
        shiftAmt = (size == 2) ? ((addr % 4) / 2) * 16 : (addr % 4) * 8;
        span     = longint'(1) << (8 * size);
        val      = (word / (longint'(1) << shiftAmt)) % span;
        if ((t == 1 || t == 3) && val >= span / 2) val = val - span + (longint'(1) << 32);
        return val[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one full load: request, optional memory reply after 'latency'
    // extra READ cycles, response check, and 'readyDelay' back-pressure cycles
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] ldType,
                                 input logic [4:0] rd, input logic [31:0] word,
                                 input int latency, input int readyDelay);
        bit          expErr;
        logic [31:0] expData;
        expErr  = refErr(int'(ldType), longint'(addr));
        expData = refData(int'(ldType), longint'(addr), longint'(word));

        @(negedge clk);
        checkOutput("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_type  = ldType;
        req_rd    = rd;

        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_type  = 3'($urandom_range(7));
        req_rd    = 5'($urandom_range(31));
        checkOutput("req_ready_busy", {31'b0, req_ready}, 32'd0);

        if (expErr) begin
            checkOutput("misalign_no_strobe", {31'b0, mem_rd_en}, 32'd0);
        end else begin
            checkOutput("mem_rd_en_rise", {31'b0, mem_rd_en}, 32'd1);
            checkOutput("mem_addr_aligned", mem_addr, addr & 32'hFFFF_FFFC);
            for (int i = 0; i < latency; i++) begin
                @(negedge clk);
                checkOutput("mem_rd_en_hold", {31'b0, mem_rd_en}, 32'd1);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = word;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            checkOutput("mem_rd_en_drop", {31'b0, mem_rd_en}, 32'd0);
        end

        checkOutput("resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("resp_err", {31'b0, resp_err}, {31'b0, expErr});
        checkOutput("resp_data", resp_data, expData);
        checkOutput("resp_rd", {27'b0, resp_rd}, {27'b0, rd});

        for (int d = 0; d < readyDelay; d++) begin
            req_valid = 1'b1;
            mem_rvalid = 1'b1;
            @(negedge clk);
            checkOutput("hold_valid", {31'b0, resp_valid}, 32'd1);
            checkOutput("hold_data", resp_data, expData);
            checkOutput("hold_err", {31'b0, resp_err}, {31'b0, expErr});
            checkOutput("hold_rd", {27'b0, resp_rd}, {27'b0, rd});
            checkOutput("hold_req_ready", {31'b0, req_ready}, 32'd0);
            checkOutput("hold_no_strobe", {31'b0, mem_rd_en}, 32'd0);
        end
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("after_hs_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("after_hs_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_mem_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        checkOutput({tag, "_resp_data"}, resp_data, 32'd0);
        checkOutput({tag, "_resp_rd"}, {27'b0, resp_rd}, 32'd0);
        checkOutput({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    endtask

    // Directed corner cases first, then a randomized sweep
    initial begin
        int cycles;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_type   = 3'd0;
        req_rd     = 5'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        $display("[TB] directed: signed byte, best-case latency");
        applyStimulus(32'h0000_1003, 3'd3, 5'd3, 32'h80FF_1234, 0, 0);
        $display("[TB] directed: halfword loads");
        applyStimulus(32'h0000_2002, 3'd2, 5'd4, 32'h8001_ABCD, 1, 0);
        applyStimulus(32'h0000_2002, 3'd1, 5'd5, 32'h8001_ABCD, 0, 0);
        $display("[TB] directed: misaligned word");
        applyStimulus(32'h0000_3002, 3'd0, 5'd6, 32'hDEAD_BEEF, 0, 2);
        $display("[TB] directed: back-pressure");
        applyStimulus(32'h0000_5004, 3'd0, 5'd9, 32'h1234_5678, 2, 5);

        $display("[TB] directed: memory timeout");
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_4000;
        req_type  = 3'd0;
        req_rd    = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        cycles = 0;
        while (mem_rd_en && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("timeout_strobe_cycles", 32'(cycles), 32'd4);
        checkOutput("timeout_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("timeout_err", {31'b0, resp_err}, 32'd1);
        checkOutput("timeout_data", resp_data, 32'd0);
        checkOutput("timeout_rd", {27'b0, resp_rd}, 32'd7);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("late_rvalid_data", resp_data, 32'd0);
        checkOutput("late_rvalid_err", {31'b0, resp_err}, 32'd1);
        checkOutput("late_rvalid_strobe", {31'b0, mem_rd_en}, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("timeout_hs_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("timeout_hs_ready", {31'b0, req_ready}, 32'd1);

        $display("[TB] directed: reset during READ");
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_6008;
        req_type  = 3'd0;
        req_rd    = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("pre_reset_strobe", {31'b0, mem_rd_en}, 32'd1);
        rst = 1'b1;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("stale_rvalid_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("stale_rvalid_ready", {31'b0, req_ready}, 32'd1);
        applyStimulus(32'h0000_7001, 3'd4, 5'd13, 32'h0000_C300, 0, 0);

        $display("[TB] randomized loads");
        for (int n = 0; n < 60; n++) begin
            applyStimulus($urandom, 3'($urandom_range(7)), 5'($urandom_range(31)),
                          $urandom, int'($urandom_range(3)), int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
